// File: rtl/retire_trace_buffer.sv
// Retirement trace buffer: captures one record per retired instruction into a
// small FIFO and streams each record out as six words over a valid/ready link.
module retire_trace_buffer #(
    parameter int         DEPTH = 8,
    parameter int         XLEN  = 32,
    parameter logic [7:0] MAGIC = 8'hA5
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    enable_i,
    input  logic                    update_i,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [XLEN-1:0]         instr_i,
    input  logic [4:0]              reg_addr_i,
    input  logic [XLEN-1:0]         reg_data_i,
    input  logic [XLEN-1:0]         mem_addr_i,
    input  logic [XLEN-1:0]         mem_data_i,
    input  logic                    mem_wrt_i,
    input  logic                    clear_i,
    output logic                    tr_valid_o,
    input  logic                    tr_ready_i,
    output logic [XLEN-1:0]         tr_data_o,
    output logic                    tr_last_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o,
    output logic [15:0]             drop_cnt_o
);
    localparam int              AW       = $clog2(DEPTH);
    localparam int              RW       = 6 * XLEN;
    localparam logic [0:0]      ST_IDLE  = 1'b0;
    localparam logic [0:0]      ST_SEND  = 1'b1;
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [2:0]      LAST_IDX = 3'd5;

    function automatic logic [XLEN-1:0] rec_word(input logic [RW-1:0] rec, input logic [2:0] idx);
        logic [XLEN-1:0] w;
        case (idx)
            3'd0:    w = rec[0*XLEN +: XLEN];
            3'd1:    w = rec[1*XLEN +: XLEN];
            3'd2:    w = rec[2*XLEN +: XLEN];
            3'd3:    w = rec[3*XLEN +: XLEN];
            3'd4:    w = rec[4*XLEN +: XLEN];
            3'd5:    w = rec[5*XLEN +: XLEN];
            default: w = {XLEN{1'b0}};
        endcase
        return w;
    endfunction

    logic [RW-1:0]    rec_mem [DEPTH];
    logic [0:0]       state_r, state_nxt_s;
    logic [2:0]       idx_r, idx_nxt_s;
    logic [AW-1:0]    rptr_r, rptr_nxt_s, wptr_r, wptr_nxt_s;
    logic [AW:0]      count_r, count_nxt_s;
    logic [15:0]      seq_r, seq_nxt_s, drop_cnt_r, drop_nxt_s;
    logic             overflow_r, ovf_nxt_s;
    logic             tr_valid_r, valid_nxt_s, tr_last_r, last_nxt_s;
    logic [XLEN-1:0]  tr_data_r, data_nxt_s;
    logic             event_s, full_s, push_s, drop_s, xfer_s, pop_s;
    logic [RW-1:0]    in_rec_s, head_rec_s;

    assign event_s  = update_i & enable_i;
    assign full_s   = (count_r == FULL_CNT);
    assign push_s   = event_s & ~full_s;
    assign drop_s   = event_s & full_s;
    assign xfer_s   = tr_valid_r & tr_ready_i;
    assign pop_s    = xfer_s & (idx_r == LAST_IDX);
    assign in_rec_s = {mem_data_i, mem_addr_i, reg_data_i, instr_i, pc_i,
                       MAGIC, 2'b00, mem_wrt_i, reg_addr_i, seq_r};

    // Occupancy, write pointer, sequence number and drop bookkeeping.
    always_comb begin
        count_nxt_s = count_r;
        wptr_nxt_s  = wptr_r;
        seq_nxt_s   = seq_r;
        drop_nxt_s  = drop_cnt_r;
        ovf_nxt_s   = overflow_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        if (push_s) begin
            wptr_nxt_s = wptr_r + PTR_ONE;
        end else begin
            wptr_nxt_s = wptr_r;
        end
        if (event_s) begin
            seq_nxt_s = seq_r + 16'd1;
        end else begin
            seq_nxt_s = seq_r;
        end
        // A drop at the same edge as a clear still leaves one drop recorded.
        if (drop_s) begin
            ovf_nxt_s  = 1'b1;
            drop_nxt_s = clear_i ? 16'd1 :
                         ((drop_cnt_r == 16'hFFFF) ? drop_cnt_r : drop_cnt_r + 16'd1);
        end else if (clear_i) begin
            ovf_nxt_s  = 1'b0;
            drop_nxt_s = 16'd0;
        end else begin
            ovf_nxt_s  = overflow_r;
            drop_nxt_s = drop_cnt_r;
        end
    end

    // Output FSM: walks the head record word by word and pops after word 5.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        rptr_nxt_s  = rptr_r;
        case (state_r)
            ST_IDLE: begin
                if (count_r != '0) begin
                    state_nxt_s = ST_SEND;
                    idx_nxt_s   = 3'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (pop_s) begin
                    rptr_nxt_s  = rptr_r + PTR_ONE;
                    idx_nxt_s   = 3'd0;
                    state_nxt_s = (count_nxt_s != '0) ? ST_SEND : ST_IDLE;
                end else if (xfer_s) begin
                    idx_nxt_s = idx_r + 3'd1;
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = 3'd0;
            end
        endcase
    end

    // Next presented word; bypasses the incoming record when it lands in the new head slot.
    always_comb begin
        if (push_s && (wptr_r == rptr_nxt_s)) begin
            head_rec_s = in_rec_s;
        end else begin
            head_rec_s = rec_mem[rptr_nxt_s];
        end
        if (state_nxt_s == ST_SEND) begin
            valid_nxt_s = 1'b1;
            data_nxt_s  = rec_word(head_rec_s, idx_nxt_s);
            last_nxt_s  = (idx_nxt_s == LAST_IDX);
        end else begin
            valid_nxt_s = 1'b0;
            data_nxt_s  = {XLEN{1'b0}};
            last_nxt_s  = 1'b0;
        end
    end

    // Record storage write port.
    always_ff @(posedge clk_i) begin
        if (rstn_i && push_s) begin
            rec_mem[wptr_r] <= in_rec_s;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r    <= ST_IDLE;
            idx_r      <= 3'd0;
            rptr_r     <= '0;
            wptr_r     <= '0;
            count_r    <= '0;
            seq_r      <= 16'd0;
            drop_cnt_r <= 16'd0;
            overflow_r <= 1'b0;
            tr_valid_r <= 1'b0;
            tr_data_r  <= {XLEN{1'b0}};
            tr_last_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            rptr_r     <= rptr_nxt_s;
            wptr_r     <= wptr_nxt_s;
            count_r    <= count_nxt_s;
            seq_r      <= seq_nxt_s;
            drop_cnt_r <= drop_nxt_s;
            overflow_r <= ovf_nxt_s;
            tr_valid_r <= valid_nxt_s;
            tr_data_r  <= data_nxt_s;
            tr_last_r  <= last_nxt_s;
        end
    end

    assign tr_valid_o = tr_valid_r;
    assign tr_data_o  = tr_data_r;
    assign tr_last_o  = tr_last_r;
    assign count_o    = count_r;
    assign overflow_o = overflow_r;
    assign drop_cnt_o = drop_cnt_r;

endmodule
